// File: rtl/memory_stage.sv
// MEM pipeline stage: issues data-bus requests via a 2-state FSM, aligns store lanes,
// extends load data and registers the MEM/WB payload. Holds stallM while an access is pending.
package memory_stage_pkg;
  typedef struct packed {
    logic        valid;
    logic [31:0] raw_instr;
    logic [63:0] pc;
    logic        regwrite;
    logic        memtoreg;
    logic        memread;
    logic        memwrite;
    logic [63:0] aluout;
    logic [4:0]  dst;
    logic [63:0] writedata;
  } execute_data_t;

  typedef struct packed {
    logic        valid;
    logic [31:0] raw_instr;
    logic [63:0] pc;
    logic        regwrite;
    logic        memtoreg;
    logic [63:0] aluout;
    logic [4:0]  dst;
    logic [63:0] readdata;
    logic        skip;
  } memory_data_t;
endpackage

module memory_stage
  import memory_stage_pkg::*;
#(
  parameter int MMIO_BIT = 31
) (
  input  logic          clk,
  input  logic          reset,
  input  execute_data_t dataE,
  output logic          dreq_valid,
  output logic [63:0]   dreq_addr,
  output logic [2:0]    dreq_size,
  output logic [7:0]    dreq_strobe,
  output logic [63:0]   dreq_data,
  input  logic          dresp_data_ok,
  input  logic [63:0]   dresp_data,
  output logic          stallM,
  output logic          misalign,
  output memory_data_t  dataM
);

  typedef enum logic {S_IDLE = 1'b0, S_WAIT = 1'b1} state_t;

  state_t       r_state, w_next;
  memory_data_t r_dataM;

  logic        w_memop;
  logic [2:0]  w_f3;
  logic [1:0]  w_size;
  logic [2:0]  w_off;
  logic        w_aligned;
  logic        w_complete;
  logic [7:0]  w_mask;
  logic [63:0] w_raw;
  logic [63:0] w_readdata;

  assign w_memop = dataE.valid & (dataE.memread | dataE.memwrite);
  assign w_f3    = dataE.raw_instr[14:12];
  assign w_size  = w_f3[1:0];
  assign w_off   = dataE.aluout[2:0];

  always_comb begin
    w_aligned = 1'b0;
    w_mask    = 8'h00;
    case (w_size)
      2'd0: begin w_aligned = 1'b1;               w_mask = 8'h01; end
      2'd1: begin w_aligned = ~w_off[0];          w_mask = 8'h03; end
      2'd2: begin w_aligned = (w_off[1:0] == 2'd0); w_mask = 8'h0F; end
      default: begin w_aligned = (w_off == 3'd0); w_mask = 8'hFF; end
    endcase
  end

  // Request fields come straight from dataE, which upstream holds stable during WAIT.
  assign dreq_addr   = dataE.aluout;
  assign dreq_size   = {1'b0, w_size};
  assign dreq_strobe = (dataE.valid & dataE.memwrite) ? (w_mask << w_off) : 8'h00;
  assign dreq_data   = dataE.writedata << {w_off, 3'b000};

  assign w_raw = dresp_data >> {w_off, 3'b000};
  always_comb begin
    w_readdata = 64'd0;
    case (w_f3)
      3'b000: w_readdata = {{56{w_raw[7]}},  w_raw[7:0]};
      3'b001: w_readdata = {{48{w_raw[15]}}, w_raw[15:0]};
      3'b010: w_readdata = {{32{w_raw[31]}}, w_raw[31:0]};
      3'b100: w_readdata = {56'd0, w_raw[7:0]};
      3'b101: w_readdata = {48'd0, w_raw[15:0]};
      3'b110: w_readdata = {32'd0, w_raw[31:0]};
      default: w_readdata = w_raw;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (dreq_valid & ~dresp_data_ok) w_next = S_WAIT;
      default: if (dresp_data_ok) w_next = S_IDLE;
    endcase
  end

  // Outputs are gated by reset so they fall in the same cycle reset asserts.
  always_comb begin
    dreq_valid = 1'b0;
    misalign   = 1'b0;
    if (reset) begin
      case (r_state)
        S_IDLE: begin
          dreq_valid = w_memop & w_aligned;
          misalign   = w_memop & ~w_aligned;
        end
        default: dreq_valid = 1'b1;
      endcase
    end
  end

  assign stallM     = dreq_valid & ~dresp_data_ok;
  assign w_complete = dreq_valid & dresp_data_ok;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_dataM <= '0;
    end else if (stallM) begin
      r_dataM.valid    <= 1'b0;
      r_dataM.regwrite <= 1'b0;
    end else begin
      r_dataM.valid     <= dataE.valid;
      r_dataM.raw_instr <= dataE.raw_instr;
      r_dataM.pc        <= dataE.pc;
      r_dataM.regwrite  <= dataE.regwrite & ~misalign;
      r_dataM.memtoreg  <= dataE.memtoreg;
      r_dataM.aluout    <= dataE.aluout;
      r_dataM.dst       <= dataE.dst;
      r_dataM.readdata  <= (w_complete & dataE.memread) ? w_readdata : 64'd0;
      r_dataM.skip      <= w_memop & ~dataE.aluout[MMIO_BIT];
    end
  end

  assign dataM = r_dataM;

endmodule

// File: tb/tb_memory_stage.sv
// Directed bench for memory_stage: bubbles, loads/stores, misalign, MMIO skip, reset in WAIT.
module tb_memory_stage;
  import memory_stage_pkg::*;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  execute_data_t dataE;
  logic          dreq_valid;
  logic [63:0]   dreq_addr;
  logic [2:0]    dreq_size;
  logic [7:0]    dreq_strobe;
  logic [63:0]   dreq_data;
  logic          dresp_data_ok = 1'b0;
  logic [63:0]   dresp_data = 64'd0;
  logic          stallM;
  logic          misalign;
  memory_data_t  dataM;

  int checks = 0;
  int failures = 0;

  memory_stage #(.MMIO_BIT(31)) dut (
    .clk(clk), .reset(reset), .dataE(dataE),
    .dreq_valid(dreq_valid), .dreq_addr(dreq_addr), .dreq_size(dreq_size),
    .dreq_strobe(dreq_strobe), .dreq_data(dreq_data),
    .dresp_data_ok(dresp_data_ok), .dresp_data(dresp_data),
    .stallM(stallM), .misalign(misalign), .dataM(dataM)
  );

  always #5 clk = ~clk;

  task automatic set_op(input logic [2:0] f3, input logic rd, input logic wr,
                        input logic [63:0] addr, input logic [63:0] wdata);
    dataE = '0;
    dataE.valid = 1'b1;
    dataE.raw_instr = {17'd0, f3, 12'h003};
    dataE.pc = 64'h1000;
    dataE.regwrite = rd;
    dataE.memtoreg = rd;
    dataE.memread = rd;
    dataE.memwrite = wr;
    dataE.aluout = addr;
    dataE.dst = 5'd7;
    dataE.writedata = wdata;
  endtask

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    dataE = '0;
    #2;
    checks++;
    if (dataM !== '0 || dreq_valid !== 1'b0 || stallM !== 1'b0 || misalign !== 1'b0) begin
      failures++;
      $display("FAIL reset_state: dataM=%h dreq_valid=%b stallM=%b misalign=%b, want all 0",
               dataM, dreq_valid, stallM, misalign);
    end
    tick();
    reset = 1'b1;
  endtask

  task automatic test_bubble();
    set_op(3'b000, 1'b0, 1'b0, 64'h1234, 64'd0);
    #1;
    checks++;
    if (dreq_valid !== 1'b0 || stallM !== 1'b0) begin
      failures++;
      $display("FAIL bubble_req: dreq_valid=%b stallM=%b want 0 0", dreq_valid, stallM);
    end
    tick();
    checks++;
    if (dataM.aluout !== 64'h1234 || dataM.valid !== 1'b1 || dataM.readdata !== 64'd0) begin
      failures++;
      $display("FAIL bubble_dataM: aluout=%h valid=%b readdata=%h want 1234 1 0",
               dataM.aluout, dataM.valid, dataM.readdata);
    end
  endtask

  task automatic test_lb_wait();
    set_op(3'b000, 1'b1, 1'b0, 64'h8000_0003, 64'd0);
    dresp_data = 64'h0000_0000_8000_0000;
    dresp_data_ok = 1'b0;
    for (int c = 0; c < 3; c++) begin
      #1;
      checks++;
      if (stallM !== 1'b1 || dreq_valid !== 1'b1 || dreq_size !== 3'd0 || dreq_strobe !== 8'h00) begin
        failures++;
        $display("FAIL lb_wait_c%0d: stallM=%b dreq_valid=%b size=%0d strobe=%h want 1 1 0 00",
                 c, stallM, dreq_valid, dreq_size, dreq_strobe);
      end
      tick();
      checks++;
      if (dataM.valid !== 1'b0 || dataM.regwrite !== 1'b0) begin
        failures++;
        $display("FAIL lb_bubble_c%0d: valid=%b regwrite=%b want 0 0", c, dataM.valid, dataM.regwrite);
      end
    end
    dresp_data_ok = 1'b1;
    #1;
    checks++;
    if (stallM !== 1'b0 || dreq_valid !== 1'b1) begin
      failures++;
      $display("FAIL lb_done_req: stallM=%b dreq_valid=%b want 0 1", stallM, dreq_valid);
    end
    tick();
    dresp_data_ok = 1'b0;
    checks++;
    if (dataM.readdata !== 64'hFFFF_FFFF_FFFF_FF80 || dataM.skip !== 1'b0 ||
        dataM.valid !== 1'b1 || dataM.regwrite !== 1'b1) begin
      failures++;
      $display("FAIL lb_result: readdata=%h skip=%b valid=%b regwrite=%b want ffffffffffffff80 0 1 1",
               dataM.readdata, dataM.skip, dataM.valid, dataM.regwrite);
    end
  endtask

  task automatic test_sh();
    set_op(3'b001, 1'b0, 1'b1, 64'h8000_0006, 64'hBEEF);
    dresp_data_ok = 1'b1;
    #1;
    checks++;
    if (dreq_valid !== 1'b1 || dreq_strobe !== 8'hC0 || dreq_data !== 64'hBEEF_0000_0000_0000 ||
        stallM !== 1'b0 || dreq_size !== 3'd1) begin
      failures++;
      $display("FAIL sh_req: valid=%b strobe=%h data=%h stallM=%b size=%0d want 1 c0 beef000000000000 0 1",
               dreq_valid, dreq_strobe, dreq_data, stallM, dreq_size);
    end
    tick();
    dresp_data_ok = 1'b0;
    checks++;
    if (dataM.valid !== 1'b1 || dataM.readdata !== 64'd0) begin
      failures++;
      $display("FAIL sh_result: valid=%b readdata=%h want 1 0", dataM.valid, dataM.readdata);
    end
  endtask

  task automatic test_misalign();
    set_op(3'b010, 1'b1, 1'b0, 64'h8000_0002, 64'd0);
    dresp_data_ok = 1'b0;
    #1;
    checks++;
    if (misalign !== 1'b1 || dreq_valid !== 1'b0 || stallM !== 1'b0) begin
      failures++;
      $display("FAIL misalign_req: misalign=%b dreq_valid=%b stallM=%b want 1 0 0",
               misalign, dreq_valid, stallM);
    end
    tick();
    checks++;
    if (dataM.valid !== 1'b1 || dataM.regwrite !== 1'b0 || dataM.readdata !== 64'd0) begin
      failures++;
      $display("FAIL misalign_result: valid=%b regwrite=%b readdata=%h want 1 0 0",
               dataM.valid, dataM.regwrite, dataM.readdata);
    end
    dataE.valid = 1'b0;
    #1;
    checks++;
    if (misalign !== 1'b0) begin
      failures++;
      $display("FAIL misalign_pulse: misalign=%b want 0", misalign);
    end
  endtask

  task automatic test_mmio();
    set_op(3'b011, 1'b1, 1'b0, 64'h4000_0000, 64'd0);
    dresp_data = 64'h0123_4567_89AB_CDEF;
    dresp_data_ok = 1'b1;
    tick();
    checks++;
    if (dataM.skip !== 1'b1 || dataM.readdata !== 64'h0123_4567_89AB_CDEF) begin
      failures++;
      $display("FAIL ld_mmio: skip=%b readdata=%h want 1 0123456789abcdef", dataM.skip, dataM.readdata);
    end
    set_op(3'b110, 1'b1, 1'b0, 64'h4000_0004, 64'd0);
    dresp_data = 64'hFFFF_FFFF_0000_0000;
    tick();
    dresp_data_ok = 1'b0;
    checks++;
    if (dataM.skip !== 1'b1 || dataM.readdata !== 64'h0000_0000_FFFF_FFFF) begin
      failures++;
      $display("FAIL lwu_mmio: skip=%b readdata=%h want 1 00000000ffffffff", dataM.skip, dataM.readdata);
    end
  endtask

  task automatic test_back_to_back();
    dresp_data_ok = 1'b1;
    set_op(3'b100, 1'b1, 1'b0, 64'h8000_0001, 64'd0);
    dresp_data = 64'h0000_0000_0000_FF00;
    #1;
    checks++;
    if (dreq_valid !== 1'b1 || stallM !== 1'b0) begin
      failures++;
      $display("FAIL b2b_req0: dreq_valid=%b stallM=%b want 1 0", dreq_valid, stallM);
    end
    tick();
    checks++;
    if (dataM.readdata !== 64'h0000_0000_0000_00FF) begin
      failures++;
      $display("FAIL b2b_lbu: readdata=%h want ff", dataM.readdata);
    end
    set_op(3'b001, 1'b1, 1'b0, 64'h8000_0000, 64'd0);
    dresp_data = 64'h0000_0000_0000_8001;
    #1;
    checks++;
    if (dreq_valid !== 1'b1 || stallM !== 1'b0) begin
      failures++;
      $display("FAIL b2b_req1: dreq_valid=%b stallM=%b want 1 0", dreq_valid, stallM);
    end
    tick();
    dresp_data_ok = 1'b0;
    checks++;
    if (dataM.readdata !== 64'hFFFF_FFFF_FFFF_8001 || dataM.valid !== 1'b1) begin
      failures++;
      $display("FAIL b2b_lh: readdata=%h valid=%b want ffffffffffff8001 1", dataM.readdata, dataM.valid);
    end
  endtask

  task automatic test_reset_in_wait();
    set_op(3'b011, 1'b1, 1'b0, 64'h8000_0008, 64'd0);
    dresp_data_ok = 1'b0;
    tick();
    checks++;
    if (stallM !== 1'b1 || dreq_valid !== 1'b1) begin
      failures++;
      $display("FAIL wait_entry: stallM=%b dreq_valid=%b want 1 1", stallM, dreq_valid);
    end
    #1;
    reset = 1'b0;
    #1;
    checks++;
    if (dreq_valid !== 1'b0 || stallM !== 1'b0 || dataM !== '0) begin
      failures++;
      $display("FAIL reset_wait: dreq_valid=%b stallM=%b dataM=%h want 0 0 0", dreq_valid, stallM, dataM);
    end
    tick();
    reset = 1'b1;
    dataE = '0;
    dresp_data_ok = 1'b1;
    dresp_data = 64'hDEAD_BEEF_DEAD_BEEF;
    #1;
    checks++;
    if (dreq_valid !== 1'b0 || stallM !== 1'b0) begin
      failures++;
      $display("FAIL late_ok_req: dreq_valid=%b stallM=%b want 0 0", dreq_valid, stallM);
    end
    tick();
    dresp_data_ok = 1'b0;
    checks++;
    if (dataM.valid !== 1'b0 || dataM.readdata !== 64'd0) begin
      failures++;
      $display("FAIL late_ok_result: valid=%b readdata=%h want 0 0", dataM.valid, dataM.readdata);
    end
  endtask

  initial begin
    dataE = '0;
    test_reset();
    test_bubble();
    test_lb_wait();
    test_sh();
    test_misalign();
    test_mmio();
    test_back_to_back();
    test_reset_in_wait();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
